// File: rtl/wheel_pkg.sv
// Shared state type, default sizes and fixed-width saturation helpers for the
// wheel integrator and the update_wheel stage.
package wheel_pkg;

  localparam int DEF_NUM_WHEELS    = 2;
  localparam int DEF_NUM_NODES     = 4;
  localparam int DEF_POSITION_SIZE = 17;
  localparam int DEF_VELOCITY_SIZE = 12;
  localparam int DEF_FORCE_SIZE    = 8;

  localparam int V_MAX = (1 << (DEF_VELOCITY_SIZE - 1)) - 1;
  localparam int V_MIN = -V_MAX - 1;
  localparam int P_MAX = (1 << (DEF_POSITION_SIZE - 1)) - 1;
  localparam int P_MIN = -P_MAX - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} integ_state_t;

  function automatic logic signed [DEF_VELOCITY_SIZE-1:0] sat_V(
    input logic signed [DEF_VELOCITY_SIZE+1:0] x
  );
    if (x > V_MAX) return DEF_VELOCITY_SIZE'(V_MAX);
    if (x < V_MIN) return DEF_VELOCITY_SIZE'(V_MIN);
    return x[DEF_VELOCITY_SIZE-1:0];
  endfunction

  function automatic logic signed [DEF_POSITION_SIZE-1:0] sat_P(
    input logic signed [DEF_POSITION_SIZE:0] x
  );
    if (x > P_MAX) return DEF_POSITION_SIZE'(P_MAX);
    if (x < P_MIN) return DEF_POSITION_SIZE'(P_MIN);
    return x[DEF_POSITION_SIZE-1:0];
  endfunction

endpackage

// File: rtl/sat_add.sv
// Signed add at IN_W bits, clamped to the signed range of OUT_W bits.
// ovf is high whenever the clamp engages.
module sat_add #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [OUT_W-1:0] sum,
  output logic                    ovf
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  logic signed [IN_W-1:0] full;

  always_comb begin
    full = a + b;
    ovf  = 1'b0;
    sum  = full[OUT_W-1:0];
    if (full > MAX_V) begin
      sum = MAX_V[OUT_W-1:0];
      ovf = 1'b1;
    end else if (full < MIN_V) begin
      sum = MIN_V[OUT_W-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/wheel_integrator.sv
// Two-stage semi-implicit Euler integrator over NUM_WHEELS x NUM_NODES nodes.
//   state | meaning
//   IDLE  | waiting for begin_in
//   RUN   | accepting force beats, one per node, wheel-major
//   DRAIN | last beat accepted, waiting for the pipeline to empty
//   DONE  | result_out pulse; begin_in here chains the next frame
module wheel_integrator
  import wheel_pkg::*;
#(
  parameter int NUM_WHEELS    = DEF_NUM_WHEELS,
  parameter int NUM_NODES     = DEF_NUM_NODES,
  parameter int POSITION_SIZE = DEF_POSITION_SIZE,
  parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
  parameter int FORCE_SIZE    = DEF_FORCE_SIZE,
  parameter int DT            = 4,
  parameter int GRAVITY       = -1,
  parameter int DAMP_SHIFT    = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic begin_in,
  input  logic [1:0][NUM_WHEELS-1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_in,
  input  logic [1:0][NUM_WHEELS-1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] velocities_in,
  input  logic signed [FORCE_SIZE-1:0]    force_x,
  input  logic signed [FORCE_SIZE-1:0]    force_y,
  input  logic                            force_valid,
  output logic                            force_ready,
  output logic signed [POSITION_SIZE-1:0] node_out_x,
  output logic signed [POSITION_SIZE-1:0] node_out_y,
  output logic signed [VELOCITY_SIZE-1:0] velocity_out_x,
  output logic signed [VELOCITY_SIZE-1:0] velocity_out_y,
  output logic                            out_valid,
  output logic [$clog2(NUM_WHEELS):0]     out_wheel,
  output logic [$clog2(NUM_NODES):0]      out_node,
  output logic                            sat_flag,
  output logic                            busy,
  output logic                            result_out
);

  localparam int WW = $clog2(NUM_WHEELS) + 1;
  localparam int NB = $clog2(NUM_NODES) + 1;
  localparam int VW = VELOCITY_SIZE + 2;
  localparam int PW = POSITION_SIZE + 1;
  localparam logic signed [VW-1:0] GRAV = VW'(GRAVITY);

  integ_state_t state, state_nxt;
  logic [WW-1:0] wheel_cnt, s1_wheel;
  logic [NB-1:0] node_cnt, s1_node;
  logic xfer, last_beat, start, s1_valid;

  logic signed [VELOCITY_SIZE-1:0] v_sel_x, v_sel_y, vnew_x, vnew_y, s1_vx, s1_vy, dv_x, dv_y;
  logic signed [POSITION_SIZE-1:0] p_sel_x, p_sel_y, pnew_x, pnew_y;
  logic signed [VW-1:0] v_ext_x, v_ext_y, vd_x, vd_y, f_ext_x, f_ext_y;
  logic signed [PW-1:0] p_ext_x, p_ext_y, dv_ext_x, dv_ext_y;
  logic vovf_x, vovf_y, povf_x, povf_y;

  assign xfer      = force_valid && force_ready;
  assign last_beat = (wheel_cnt == WW'(NUM_WHEELS - 1)) && (node_cnt == NB'(NUM_NODES - 1));
  assign start     = begin_in && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    force_ready = 1'b0;
    busy        = 1'b0;
    result_out  = 1'b0;
    case (state)
      IDLE:  if (begin_in) state_nxt = RUN;
      RUN: begin
        force_ready = 1'b1;
        busy        = 1'b1;
        if (xfer && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!s1_valid) state_nxt = DONE;
      end
      DONE: begin
        result_out = 1'b1;
        state_nxt  = begin_in ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Node selection: velocities by the accept counters, positions by the stage-1 tag.
  always_comb begin
    v_sel_x = '0;
    v_sel_y = '0;
    p_sel_x = '0;
    p_sel_y = '0;
    for (int w = 0; w < NUM_WHEELS; w++) begin
      for (int n = 0; n < NUM_NODES; n++) begin
        if ((wheel_cnt == WW'(w)) && (node_cnt == NB'(n))) begin
          v_sel_x = velocities_in[0][w][n];
          v_sel_y = velocities_in[1][w][n];
        end
        if ((s1_wheel == WW'(w)) && (s1_node == NB'(n))) begin
          p_sel_x = nodes_in[0][w][n];
          p_sel_y = nodes_in[1][w][n];
        end
      end
    end
  end

  assign v_ext_x = v_sel_x;
  assign v_ext_y = v_sel_y;
  assign vd_x    = (DAMP_SHIFT == 0) ? v_ext_x : v_ext_x - (v_ext_x >>> DAMP_SHIFT);
  assign vd_y    = (DAMP_SHIFT == 0) ? v_ext_y : v_ext_y - (v_ext_y >>> DAMP_SHIFT);
  assign f_ext_x = force_x;
  assign f_ext_y = VW'(force_y) + GRAV;

  sat_add #(.IN_W(VW), .OUT_W(VELOCITY_SIZE)) u_vel_x (.a(vd_x), .b(f_ext_x), .sum(vnew_x), .ovf(vovf_x));
  sat_add #(.IN_W(VW), .OUT_W(VELOCITY_SIZE)) u_vel_y (.a(vd_y), .b(f_ext_y), .sum(vnew_y), .ovf(vovf_y));

  assign dv_x     = s1_vx >>> DT;
  assign dv_y     = s1_vy >>> DT;
  assign dv_ext_x = dv_x;
  assign dv_ext_y = dv_y;
  assign p_ext_x  = p_sel_x;
  assign p_ext_y  = p_sel_y;

  sat_add #(.IN_W(PW), .OUT_W(POSITION_SIZE)) u_pos_x (.a(p_ext_x), .b(dv_ext_x), .sum(pnew_x), .ovf(povf_x));
  sat_add #(.IN_W(PW), .OUT_W(POSITION_SIZE)) u_pos_y (.a(p_ext_y), .b(dv_ext_y), .sum(pnew_y), .ovf(povf_y));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wheel_cnt <= '0;
      node_cnt  <= '0;
      sat_flag  <= 1'b0;
    end else if (start) begin
      wheel_cnt <= '0;
      node_cnt  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (xfer) begin
        if (node_cnt == NB'(NUM_NODES - 1)) begin
          node_cnt  <= '0;
          wheel_cnt <= wheel_cnt + WW'(1);
        end else begin
          node_cnt <= node_cnt + NB'(1);
        end
      end
      if ((xfer && (vovf_x || vovf_y)) || (s1_valid && (povf_x || povf_y)))
        sat_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid       <= 1'b0;
      s1_vx          <= '0;
      s1_vy          <= '0;
      s1_wheel       <= '0;
      s1_node        <= '0;
      out_valid      <= 1'b0;
      node_out_x     <= '0;
      node_out_y     <= '0;
      velocity_out_x <= '0;
      velocity_out_y <= '0;
      out_wheel      <= '0;
      out_node       <= '0;
    end else begin
      s1_valid  <= xfer;
      out_valid <= s1_valid;
      if (xfer) begin
        s1_vx    <= vnew_x;
        s1_vy    <= vnew_y;
        s1_wheel <= wheel_cnt;
        s1_node  <= node_cnt;
      end
      if (s1_valid) begin
        node_out_x     <= pnew_x;
        node_out_y     <= pnew_y;
        velocity_out_x <= s1_vx;
        velocity_out_y <= s1_vy;
        out_wheel      <= s1_wheel;
        out_node       <= s1_node;
      end
    end
  end

endmodule

// File: tb/tb_wheel_integrator.sv
// Randomised bench for wheel_integrator: two instances (damping shift 4 and 0)
// share one stimulus stream and are compared against an arithmetic model.
module tb_wheel_integrator;

  localparam int NW = 2, NN = 4, PS = 17, VS = 12, FS = 8, DT = 4, GRAV = -1;
  localparam int NBEAT = NW * NN;

  logic clk_in = 1'b0;
  logic rst_in, begin_in, force_valid;
  logic [1:0][NW-1:0][NN-1:0][PS-1:0] nodes_in;
  logic [1:0][NW-1:0][NN-1:0][VS-1:0] velocities_in;
  logic signed [FS-1:0] force_x, force_y;

  logic force_ready[2], out_valid[2], sat_flag[2], busy[2], result_out[2];
  logic signed [PS-1:0] nox[2], noy[2];
  logic signed [VS-1:0] vox[2], voy[2];
  logic [1:0] owheel[2];
  logic [2:0] onode[2];

  int ds_of[2] = '{4, 0};
  int n_checks = 0, n_errors = 0, cyc = 0;

  int px[NBEAT], py[NBEAT], vx[NBEAT], vy[NBEAT], fx[NBEAT], fy[NBEAT];
  int e_px[2][NBEAT], e_py[2][NBEAT], e_vx[2][NBEAT], e_vy[2][NBEAT];
  bit e_sat[2];

  always #5 clk_in = ~clk_in;

  wheel_integrator #(.DAMP_SHIFT(4)) dut_d4 (
    .clk_in(clk_in), .rst_in(rst_in), .begin_in(begin_in),
    .nodes_in(nodes_in), .velocities_in(velocities_in),
    .force_x(force_x), .force_y(force_y), .force_valid(force_valid),
    .force_ready(force_ready[0]),
    .node_out_x(nox[0]), .node_out_y(noy[0]),
    .velocity_out_x(vox[0]), .velocity_out_y(voy[0]),
    .out_valid(out_valid[0]), .out_wheel(owheel[0]), .out_node(onode[0]),
    .sat_flag(sat_flag[0]), .busy(busy[0]), .result_out(result_out[0])
  );

  wheel_integrator #(.DAMP_SHIFT(0)) dut_d0 (
    .clk_in(clk_in), .rst_in(rst_in), .begin_in(begin_in),
    .nodes_in(nodes_in), .velocities_in(velocities_in),
    .force_x(force_x), .force_y(force_y), .force_valid(force_valid),
    .force_ready(force_ready[1]),
    .node_out_x(nox[1]), .node_out_y(noy[1]),
    .velocity_out_x(vox[1]), .velocity_out_y(voy[1]),
    .out_valid(out_valid[1]), .out_wheel(owheel[1]), .out_node(onode[1]),
    .sat_flag(sat_flag[1]), .busy(busy[1]), .result_out(result_out[1])
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int clamp(input int x, input int w);
    int mx = (1 << (w - 1)) - 1;
    int mn = -mx - 1;
    if (x > mx) return mx;
    if (x < mn) return mn;
    return x;
  endfunction

  task automatic model_beat(input int ds, input int p, input int v, input int f, input int g,
                            output int pn, output int vn, output bit hit);
    int vd, vr, pr;
    vd = (ds == 0) ? v : v - (v >>> ds);
    vr = vd + f + g;
    vn = clamp(vr, VS);
    pr = p + (vn >>> DT);
    pn = clamp(pr, PS);
    hit = (vn != vr) || (pn != pr);
  endtask

  function automatic int rnd(input int lim);
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  task automatic apply_frame();
    bit hx, hy;
    for (int w = 0; w < NW; w++)
      for (int n = 0; n < NN; n++) begin
        nodes_in[0][w][n]      = PS'(px[w*NN+n]);
        nodes_in[1][w][n]      = PS'(py[w*NN+n]);
        velocities_in[0][w][n] = VS'(vx[w*NN+n]);
        velocities_in[1][w][n] = VS'(vy[w*NN+n]);
      end
    for (int d = 0; d < 2; d++) begin
      e_sat[d] = 1'b0;
      for (int k = 0; k < NBEAT; k++) begin
        model_beat(ds_of[d], px[k], vx[k], fx[k], 0, e_px[d][k], e_vx[d][k], hx);
        model_beat(ds_of[d], py[k], vy[k], fy[k], GRAV, e_py[d][k], e_vy[d][k], hy);
        e_sat[d] = e_sat[d] | hx | hy;
      end
    end
  endtask

  task automatic gen_random(input int pl, input int vl, input int fl);
    for (int k = 0; k < NBEAT; k++) begin
      px[k] = rnd(pl); py[k] = rnd(pl);
      vx[k] = rnd(vl); vy[k] = rnd(vl);
      fx[k] = rnd(fl); fy[k] = rnd(fl);
    end
    apply_frame();
  endtask

  task automatic gen_directed();
    gen_random(500, 200, 50);
    px[0] = -30;   py[0] = -20; vx[0] = 0;    vy[0] = 0; fx[0] = 0;   fy[0] = 0;
    px[1] = -30;   py[1] = -20; vx[1] = 64;   vy[1] = 0; fx[1] = 0;   fy[1] = 0;
    px[2] = 100;   py[2] = 0;   vx[2] = 2040; vy[2] = 0; fx[2] = 127; fy[2] = 0;
    px[3] = 65530; py[3] = 0;   vx[3] = 2047; vy[3] = 0; fx[3] = 0;   fy[3] = 0;
    apply_frame();
  endtask

  task automatic check_idle_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq({tag, "_force_ready"}, force_ready[d], 0);
      check_eq({tag, "_out_valid"}, out_valid[d], 0);
      check_eq({tag, "_busy"}, busy[d], 0);
      check_eq({tag, "_result_out"}, result_out[d], 0);
      check_eq({tag, "_sat_flag"}, sat_flag[d], 0);
      check_eq({tag, "_node_x"}, nox[d], 0);
      check_eq({tag, "_node_y"}, noy[d], 0);
      check_eq({tag, "_vel_x"}, vox[d], 0);
      check_eq({tag, "_vel_y"}, voy[d], 0);
      check_eq({tag, "_wheel"}, owheel[d], 0);
      check_eq({tag, "_node"}, onode[d], 0);
    end
  endtask

  task automatic run_frame(input int gap_pct, input bit pre_begun, input bit chain);
    int acc, outs, last_out, bcyc, k;
    int acc_cyc[NBEAT];
    bit done, exp_ov, exp_res;
    acc = 0; outs = 0; last_out = -10; done = 1'b0;
    if (!pre_begun) begin
      @(negedge clk_in); cyc++;
    end
    begin_in = 1'b1;
    force_valid = 1'b0;
    bcyc = cyc;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk_in); cyc++;
      begin_in = 1'b0;
      force_valid = 1'b0;
      exp_ov  = (outs < acc) && (cyc == acc_cyc[outs] + 2);
      exp_res = (outs == NBEAT) && (cyc == last_out + 1);
      for (int d = 0; d < 2; d++) begin
        check_eq("force_ready", force_ready[d], acc < NBEAT);
        check_eq("busy", busy[d], !exp_res);
        check_eq("out_valid", out_valid[d], exp_ov);
        check_eq("result_out", result_out[d], exp_res);
        if (cyc == bcyc + 1) check_eq("sat_clear", sat_flag[d], 0);
        if (exp_res) check_eq("sat_flag", sat_flag[d], e_sat[d]);
        if (exp_ov) begin
          k = outs;
          check_eq("node_x", nox[d], e_px[d][k]);
          check_eq("node_y", noy[d], e_py[d][k]);
          check_eq("vel_x", vox[d], e_vx[d][k]);
          check_eq("vel_y", voy[d], e_vy[d][k]);
          check_eq("out_wheel", owheel[d], k / NN);
          check_eq("out_node", onode[d], k % NN);
        end
      end
      if (exp_ov) begin
        outs++;
        last_out = cyc;
      end
      if (exp_res) done = 1'b1;
      if (done) begin
        begin_in = chain;
      end else begin
        force_valid = ($urandom_range(0, 99) >= gap_pct);
        force_x = FS'($urandom);
        force_y = FS'($urandom);
        begin_in = ($urandom_range(0, 7) == 0);
        if (force_valid && acc < NBEAT) begin
          force_x = FS'(fx[acc]);
          force_y = FS'(fy[acc]);
          acc_cyc[acc] = cyc;
          acc++;
        end
      end
    end
    if (!done) check_eq("frame_timeout", 0, 1);
  endtask

  task automatic reset_mid();
    gen_random(2000, 500, 100);
    @(negedge clk_in); cyc++;
    begin_in = 1'b1; force_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in); cyc++;
      begin_in = 1'b0;
      force_valid = 1'b1;
      force_x = FS'(fx[i]);
      force_y = FS'(fy[i]);
    end
    @(negedge clk_in); cyc++;
    force_valid = 1'b0;
    rst_in = 1'b1;
    #1 check_idle_zero("rst_mid");
    @(negedge clk_in); cyc++;
    rst_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in); cyc++;
      for (int d = 0; d < 2; d++) begin
        check_eq("rst_no_result", result_out[d], 0);
        check_eq("rst_no_valid", out_valid[d], 0);
        check_eq("rst_not_busy", busy[d], 0);
      end
    end
  endtask

  initial begin
    rst_in = 1'b1;
    begin_in = 1'b0;
    force_valid = 1'b0;
    force_x = '0;
    force_y = '0;
    nodes_in = '0;
    velocities_in = '0;
    repeat (3) @(negedge clk_in);
    check_idle_zero("reset");
    rst_in = 1'b0;

    gen_directed();
    run_frame(0, 1'b0, 1'b0);
    gen_random(1000, 500, 100);
    run_frame(30, 1'b0, 1'b0);
    gen_random(65535, 2047, 127);
    run_frame(40, 1'b0, 1'b1);
    gen_random(1000, 300, 60);
    run_frame(20, 1'b1, 1'b0);
    reset_mid();
    gen_random(3000, 800, 127);
    run_frame(50, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      gen_random((i % 2 == 0) ? 65535 : 5000, 2047, 127);
      run_frame(int'($urandom_range(0, 60)), 1'b0, i[0]);
      if (i[0]) begin
        gen_random(4000, 1000, 127);
        run_frame(25, 1'b1, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
